// File: rtl/rv32i_single_cycle_core.sv
// Single-cycle RV32I core: one instruction fetched, executed and retired per clock.
// Instruction ROM and data memory are synchronous and clocked from the core clock outputs.

module rv32i_regfile (
    input  logic        clock,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2
);

    logic [31:0] regs [0:31];

    always_ff @(posedge clock) begin
        if (we && (waddr != 5'd0)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == 5'd0) ? 32'd0 : regs[raddr1];
    assign rdata2 = (raddr2 == 5'd0) ? 32'd0 : regs[raddr2];

endmodule

module rv32i_single_cycle_core #(
    parameter logic [31:0] RESET_PC = 32'h00000000
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] imemaddr,
    input  logic [31:0] imemdataout,
    output logic        imemclk,
    output logic [31:0] dmemaddr,
    input  logic [31:0] dmemdataout,
    output logic [31:0] dmemdatain,
    output logic        dmemrdclk,
    output logic        dmemwrclk,
    output logic [2:0]  dmemop,
    output logic        dmemwe,
    output logic [31:0] dbgdata
);

    localparam logic [6:0] OpLui    = 7'h37;
    localparam logic [6:0] OpAuipc  = 7'h17;
    localparam logic [6:0] OpJal    = 7'h6f;
    localparam logic [6:0] OpJalr   = 7'h67;
    localparam logic [6:0] OpBranch = 7'h63;
    localparam logic [6:0] OpLoad   = 7'h03;
    localparam logic [6:0] OpStore  = 7'h23;
    localparam logic [6:0] OpImm    = 7'h13;
    localparam logic [6:0] OpReg    = 7'h33;

    logic [31:0] pc_q;
    logic [31:0] nextpc;
    logic [31:0] pc_plus4;
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic        alt;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] alu_b;
    logic [4:0]  shamt;
    logic [31:0] alu_res;
    logic        br_taken;
    logic        rd_we;
    logic [31:0] rd_data;

    assign instr  = imemdataout;
    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign alt    = instr[30];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'd0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    rv32i_regfile myregfile (
        .clock  (clock),
        .we     (rd_we),
        .waddr  (rd),
        .wdata  (rd_data),
        .raddr1 (rs1),
        .raddr2 (rs2),
        .rdata1 (rs1_data),
        .rdata2 (rs2_data)
    );

    always_comb begin
        alu_b = (opcode == OpReg) ? rs2_data : imm_i;
        shamt = alu_b[4:0];
        case (funct3)
            3'd0:    alu_res = ((opcode == OpReg) && alt) ? rs1_data - alu_b : rs1_data + alu_b;
            3'd1:    alu_res = rs1_data << shamt;
            3'd2:    alu_res = {31'd0, $signed(rs1_data) < $signed(alu_b)};
            3'd3:    alu_res = {31'd0, rs1_data < alu_b};
            3'd4:    alu_res = rs1_data ^ alu_b;
            3'd5:    alu_res = alt ? $unsigned($signed(rs1_data) >>> shamt) : rs1_data >> shamt;
            3'd6:    alu_res = rs1_data | alu_b;
            default: alu_res = rs1_data & alu_b;
        endcase
    end

    always_comb begin
        case (funct3)
            3'd0:    br_taken = (rs1_data == rs2_data);
            3'd1:    br_taken = (rs1_data != rs2_data);
            3'd4:    br_taken = ($signed(rs1_data) < $signed(rs2_data));
            3'd5:    br_taken = ($signed(rs1_data) >= $signed(rs2_data));
            3'd6:    br_taken = (rs1_data < rs2_data);
            3'd7:    br_taken = (rs1_data >= rs2_data);
            default: br_taken = 1'b0;
        endcase
    end

    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        nextpc  = pc_plus4;
        rd_we   = 1'b0;
        rd_data = alu_res;
        case (opcode)
            OpLui: begin
                rd_we   = 1'b1;
                rd_data = imm_u;
            end
            OpAuipc: begin
                rd_we   = 1'b1;
                rd_data = pc_q + imm_u;
            end
            OpJal: begin
                rd_we   = 1'b1;
                rd_data = pc_plus4;
                nextpc  = pc_q + imm_j;
            end
            OpJalr: begin
                rd_we   = 1'b1;
                rd_data = pc_plus4;
                nextpc  = (rs1_data + imm_i) & 32'hffff_fffe;
            end
            OpBranch: begin
                if (br_taken) begin
                    nextpc = pc_q + imm_b;
                end
            end
            OpLoad: begin
                rd_we   = 1'b1;
                rd_data = dmemdataout;
            end
            OpImm, OpReg: begin
                rd_we = 1'b1;
            end
            default: ;
        endcase
        // Hold fetch at the reset vector so the ROM presents it when reset releases.
        if (!reset) begin
            nextpc = RESET_PC;
            rd_we  = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= nextpc;
        end
    end

    assign imemaddr   = nextpc;
    assign imemclk    = clock;
    assign dmemrdclk  = ~clock;
    assign dmemwrclk  = clock;
    assign dmemaddr   = rs1_data + ((opcode == OpStore) ? imm_s : imm_i);
    assign dmemdatain = rs2_data;
    assign dmemop     = funct3;
    assign dmemwe     = reset && (opcode == OpStore);
    assign dbgdata    = pc_q;

endmodule

// File: tb/tb_rv32i_single_cycle_core.sv
// Lockstep bench: directed program followed by random instructions, compared each cycle
// against an instruction-level reference model.

module tb_rv32i_single_cycle_core;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] imemaddr;
    logic [31:0] imemdataout;
    logic        imemclk;
    logic [31:0] dmemaddr;
    logic [31:0] dmemdataout;
    logic [31:0] dmemdatain;
    logic        dmemrdclk;
    logic        dmemwrclk;
    logic [2:0]  dmemop;
    logic        dmemwe;
    logic [31:0] dbgdata;

    rv32i_single_cycle_core #(
        .RESET_PC (32'h00000000)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .imemaddr    (imemaddr),
        .imemdataout (imemdataout),
        .imemclk     (imemclk),
        .dmemaddr    (dmemaddr),
        .dmemdataout (dmemdataout),
        .dmemdatain  (dmemdatain),
        .dmemrdclk   (dmemrdclk),
        .dmemwrclk   (dmemwrclk),
        .dmemop      (dmemop),
        .dmemwe      (dmemwe),
        .dbgdata     (dbgdata)
    );

    always #5 clock = ~clock;

    logic [31:0] rom    [0:1023];
    logic [7:0]  dmem   [0:255];
    logic [7:0]  m_mem  [0:255];
    logic [31:0] m_regs [0:31];
    logic [31:0] m_pc;
    logic [31:0] pos;
    logic [31:0] end_pc;
    int          n_checks;
    int          n_fail;

    // Environment memories
    always @(posedge imemclk) imemdataout <= rom[imemaddr[11:2]];
    always @(posedge dmemrdclk) dmemdataout <= env_read(dmemaddr[7:0], dmemop);
    always @(posedge dmemwrclk) begin
        if (dmemwe) begin
            dmem[dmemaddr[7:0]] <= dmemdatain[7:0];
            if (dmemop[1:0] != 2'd0) dmem[dmemaddr[7:0] + 8'd1] <= dmemdatain[15:8];
            if (dmemop[1]) begin
                dmem[dmemaddr[7:0] + 8'd2] <= dmemdatain[23:16];
                dmem[dmemaddr[7:0] + 8'd3] <= dmemdatain[31:24];
            end
        end
    end

    function automatic logic [31:0] extend(input logic [31:0] w, input logic [2:0] op);
        case (op)
            3'd0:    return {{24{w[7]}}, w[7:0]};
            3'd1:    return {{16{w[15]}}, w[15:0]};
            3'd4:    return {24'd0, w[7:0]};
            3'd5:    return {16'd0, w[15:0]};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] env_read(input logic [7:0] a, input logic [2:0] op);
        return extend({dmem[a + 8'd3], dmem[a + 8'd2], dmem[a + 8'd1], dmem[a]}, op);
    endfunction

    function automatic logic [31:0] model_read(input logic [7:0] a, input logic [2:0] op);
        return extend({m_mem[a + 8'd3], m_mem[a + 8'd2], m_mem[a + 8'd1], m_mem[a]}, op);
    endfunction

    task automatic model_write(input logic [7:0] a, input logic [2:0] op, input logic [31:0] v);
        int nbytes;
        nbytes = (op[1:0] == 2'd0) ? 1 : (op[1:0] == 2'd1) ? 2 : 4;
        for (int i = 0; i < nbytes; i++) m_mem[a + 8'(i)] = v[8*i +: 8];
    endtask

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rd, op};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
    endfunction

    task automatic emit(input logic [31:0] w);
        rom[pos[11:2]] = w;
        pos = pos + 32'd4;
    endtask

    function automatic logic [31:0] rand_instr();
        int          k;
        int          sz;
        logic [4:0]  rd;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [2:0]  f3;
        logic [11:0] imm;
        logic [6:0]  f7;
        k  = $urandom_range(0, 9);
        rd = 5'($urandom_range(0, 15));
        r1 = 5'($urandom_range(0, 15));
        r2 = 5'($urandom_range(0, 15));
        f3 = 3'($urandom_range(0, 7));
        case (k)
            0, 1, 2, 3: begin
                imm = 12'($urandom);
                if (f3 == 3'd1) imm = {7'd0, imm[4:0]};
                if (f3 == 3'd5) imm = {1'b0, imm[10], 5'd0, imm[4:0]};
                return enc_i(imm, r1, f3, rd, 7'h13);
            end
            4, 5: begin
                f7 = ((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
                return enc_r(f7, r2, r1, f3, rd);
            end
            6: return enc_u(20'($urandom), rd, ($urandom_range(0, 1) == 1) ? 7'h37 : 7'h17);
            7: begin
                sz  = $urandom_range(0, 2);
                imm = 12'($urandom_range(0, 255) & ~((1 << sz) - 1));
                return enc_s(imm, r2, 5'd0, 3'(sz));
            end
            8: begin
                case ($urandom_range(0, 4))
                    0: f3 = 3'd0;
                    1: f3 = 3'd1;
                    2: f3 = 3'd2;
                    3: f3 = 3'd4;
                    default: f3 = 3'd5;
                endcase
                sz  = int'(f3[1:0]);
                imm = 12'($urandom_range(0, 255) & ~((1 << sz) - 1));
                return enc_i(imm, 5'd0, f3, rd, 7'h03);
            end
            default: begin
                if (f3 == 3'd2 || f3 == 3'd3) f3 = 3'd0;
                return enc_b(13'd8, r2, r1, f3);
            end
        endcase
    endfunction

    function automatic logic [31:0] ref_alu(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b, input logic sub,
                                            input logic sra);
        case (f3)
            3'd0:    return sub ? a - b : a + b;
            3'd1:    return a << b[4:0];
            3'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3:    return (a < b) ? 32'd1 : 32'd0;
            3'd4:    return a ^ b;
            3'd5:    return sra ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'd6:    return a | b;
            default: return a & b;
        endcase
    endfunction

    // Check the DUT's visible outputs for the instruction at m_pc, then retire it in the model.
    task automatic step_and_check(output logic [4:0] wrd);
        logic [31:0] ins, a, b, ii, is, ib, iu, ij, val, nxt, addr;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic        wr, taken;
        ins = rom[m_pc[11:2]];
        op  = ins[6:0];
        rd  = ins[11:7];
        f3  = ins[14:12];
        a   = m_regs[ins[19:15]];
        b   = m_regs[ins[24:20]];
        ii  = {{20{ins[31]}}, ins[31:20]};
        is  = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        ib  = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        iu  = {ins[31:12], 12'd0};
        ij  = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        nxt = m_pc + 32'd4;
        wr  = 1'b0;
        val = 32'd0;
        check_val("dbgdata", dbgdata, m_pc);
        check_val("dmemwe", {31'd0, dmemwe}, {31'd0, op == 7'h23});
        case (op)
            7'h37: begin wr = 1'b1; val = iu; end
            7'h17: begin wr = 1'b1; val = m_pc + iu; end
            7'h6f: begin wr = 1'b1; val = m_pc + 32'd4; nxt = m_pc + ij; end
            7'h67: begin wr = 1'b1; val = m_pc + 32'd4; nxt = (a + ii) & ~32'd1; end
            7'h63: begin
                case (f3)
                    3'd0:    taken = (a == b);
                    3'd1:    taken = (a != b);
                    3'd4:    taken = ($signed(a) < $signed(b));
                    3'd5:    taken = ($signed(a) >= $signed(b));
                    3'd6:    taken = (a < b);
                    default: taken = (a >= b);
                endcase
                if (taken) nxt = m_pc + ib;
            end
            7'h03: begin
                addr = a + ii;
                check_val("ld_addr", dmemaddr, addr);
                check_val("ld_op", {29'd0, dmemop}, {29'd0, f3});
                wr  = 1'b1;
                val = model_read(addr[7:0], f3);
            end
            7'h23: begin
                addr = a + is;
                check_val("st_addr", dmemaddr, addr);
                check_val("st_op", {29'd0, dmemop}, {29'd0, f3});
                check_val("st_data", dmemdatain, b);
                model_write(addr[7:0], f3, b);
            end
            7'h13: begin wr = 1'b1; val = ref_alu(f3, a, ii, 1'b0, ins[30]); end
            7'h33: begin wr = 1'b1; val = ref_alu(f3, a, b, ins[30], ins[30]); end
            default: ;
        endcase
        check_val("imemaddr", imemaddr, nxt);
        if (wr && rd != 5'd0) m_regs[rd] = val;
        wrd  = (wr) ? rd : 5'd0;
        m_pc = nxt;
    endtask

    initial begin
        int          cycles;
        logic [4:0]  wrd;
        logic [31:0] mw;
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < 1024; i++) rom[i] = 32'h00000013;
        for (int i = 0; i < 256; i++) begin
            dmem[i]  = 8'($urandom);
            m_mem[i] = dmem[i];
        end
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;

        pos = 32'h0;
        emit(enc_i(12'hfff, 5'd0, 3'd0, 5'd1, 7'h13));   // addi x1,x0,-1
        emit(enc_i(12'h404, 5'd1, 3'd5, 5'd2, 7'h13));   // srai x2,x1,4
        emit(enc_i(12'h01c, 5'd1, 3'd5, 5'd3, 7'h13));   // srli x3,x1,28
        emit(enc_r(7'h00, 5'd1, 5'd0, 3'd3, 5'd4));      // sltu x4,x0,x1
        emit(enc_u(20'h00001, 5'd6, 7'h17));             // auipc x6,1 at 0x10
        emit(enc_i(12'd5, 5'd0, 3'd0, 5'd0, 7'h13));     // addi x0,x0,5
        emit(enc_u(20'h12345, 5'd5, 7'h37));             // lui x5,0x12345
        emit(enc_s(12'd0, 5'd5, 5'd0, 3'd2));            // sw x5,0(x0)
        emit(enc_s(12'd1, 5'd1, 5'd0, 3'd0));            // sb x1,1(x0)
        emit(enc_i(12'd1, 5'd0, 3'd4, 5'd7, 7'h03));     // lbu x7,1(x0)
        emit(enc_i(12'd1, 5'd0, 3'd0, 5'd8, 7'h03));     // lb x8,1(x0)
        emit(enc_i(12'd0, 5'd0, 3'd2, 5'd9, 7'h03));     // lw x9,0(x0)
        emit(32'h00000013);
        emit(32'h0000000f);                              // fence
        emit(32'hdead10cc);
        emit(32'h00000073);                              // ecall
        emit(enc_b(13'd8, 5'd0, 5'd0, 3'd0));            // 0x40 beq x0,x0,+8
        emit(enc_i(12'd1, 5'd0, 3'd0, 5'd12, 7'h13));
        emit(enc_b(13'd8, 5'd0, 5'd1, 3'd5));            // 0x48 bge x1,x0,+8
        emit(enc_i(12'd7, 5'd0, 3'd0, 5'd13, 7'h13));
        emit(enc_j(21'h100, 5'd1));                      // 0x50 jal x1,+0x100
        pos = 32'h150;
        emit(enc_i(12'h161, 5'd0, 3'd0, 5'd1, 7'h13));
        emit(enc_i(12'd3, 5'd1, 3'd0, 5'd1, 7'h67));     // jalr x1,x1,3
        for (int i = 0; i < 3; i++) emit(enc_i(12'd2, 5'd0, 3'd0, 5'd12, 7'h13));
        for (int i = 1; i < 16; i++) begin
            emit(enc_u(20'($urandom), 5'(i), 7'h37));
            emit(enc_i(12'($urandom), 5'(i), 3'd0, 5'(i), 7'h13));
        end
        for (int i = 0; i < 300; i++) emit(rand_instr());
        emit(32'h00000013);
        emit(32'h00000013);
        emit(enc_u(20'h00c10, 5'd10, 7'h37));
        emit(enc_i(12'hfee, 5'd10, 3'd0, 5'd10, 7'h13));
        end_pc = pos;
        emit(32'hdead10cc);

        reset = 1'b0;
        m_pc  = 32'h0;
        @(posedge clock);
        #1;
        check_val("rst_dbgdata", dbgdata, 32'h0);
        check_val("rst_imemaddr", imemaddr, 32'h0);
        check_val("rst_dmemwe", {31'd0, dmemwe}, 32'd0);
        @(negedge clock);
        reset = 1'b1;

        cycles = 0;
        while (m_pc != end_pc && cycles < 10000) begin
            #1;
            case (m_pc)
                32'h04: check_val("x1_addi", dut.myregfile.regs[1], 32'hffffffff);
                32'h40: begin
                    check_val("x2_srai", dut.myregfile.regs[2], 32'hffffffff);
                    check_val("x3_srli", dut.myregfile.regs[3], 32'h0000000f);
                    check_val("x4_sltu", dut.myregfile.regs[4], 32'h00000001);
                    check_val("x5_lui", dut.myregfile.regs[5], 32'h12345000);
                    check_val("x6_auipc", dut.myregfile.regs[6], 32'h00001010);
                    check_val("x7_lbu", dut.myregfile.regs[7], 32'h000000ff);
                    check_val("x8_lb", dut.myregfile.regs[8], 32'hffffffff);
                    check_val("x9_lw", dut.myregfile.regs[9], 32'h1234ff00);
                    check_val("mem0", {dmem[3], dmem[2], dmem[1], dmem[0]}, 32'h1234ff00);
                end
                32'h150: check_val("x1_jal", dut.myregfile.regs[1], 32'h00000054);
                32'h164: begin
                    check_val("x1_jalr", dut.myregfile.regs[1], 32'h00000158);
                    check_val("x13_bge", dut.myregfile.regs[13], 32'h00000007);
                end
                default: ;
            endcase
            step_and_check(wrd);
            @(posedge clock);
            #1;
            if (wrd != 5'd0) check_val($sformatf("x%0d", wrd), dut.myregfile.regs[wrd], m_regs[wrd]);
            @(negedge clock);
            cycles++;
        end
        #1;
        check_val("end_pc", m_pc, end_pc);
        check_val("end_dbgdata", dbgdata, end_pc);
        check_val("x10_pass", dut.myregfile.regs[10], 32'h00c0ffee);
        for (int i = 0; i < 64; i++) begin
            mw = {m_mem[4*i+3], m_mem[4*i+2], m_mem[4*i+1], m_mem[4*i]};
            check_val($sformatf("mem%0d", i),
                      {dmem[4*i+3], dmem[4*i+2], dmem[4*i+1], dmem[4*i]}, mw);
        end

        // Asynchronous reset mid-cycle
        @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        check_val("arst_dbgdata", dbgdata, 32'h0);
        check_val("arst_imemaddr", imemaddr, 32'h0);
        check_val("arst_dmemwe", {31'd0, dmemwe}, 32'd0);
        @(posedge clock);
        #1;
        check_val("arst_x10_kept", dut.myregfile.regs[10], 32'h00c0ffee);
        check_val("arst_hold_pc", dbgdata, 32'h0);
        reset = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
